// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } uart_arb_state_t;

    // One counter serves both the busy timeout and the inter-frame gap.
    function automatic int cnt_width(input int timeout, input int gap);
        int m;
        m = (timeout > gap) ? timeout : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner select: rotate so (last+1) is bit 0, pick lowest set, rotate back.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any_req,
    output logic [IDX_W-1:0] winner
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] offs;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % N_REQ);
    endfunction

    always_comb begin
        rot     = '0;
        offs    = '0;
        any_req = |req;
        for (int i = 0; i < N_REQ; i++)
            rot[i] = req[wrap_idx(int'(last) + 1 + i)];
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) offs = IDX_W'(i);
        winner = wrap_idx(int'(last) + 1 + int'(offs));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters, one frame per round-robin grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            ack,
    output logic                        tx_err,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        arb_busy,
    output logic                        uart_enable,
    output logic [DATA_WIDTH-1:0]       uart_data,
    input  logic                        uart_busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(BUSY_TIMEOUT, GAP_CYCLES);
    localparam uart_arb_state_t AFTER_ACK = (GAP_CYCLES == 0) ? IDLE : GAP;

    uart_arb_state_t       state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      last, winner;
    logic                  any_req, launch, done;
    logic [DATA_WIDTH-1:0] req_word [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req     (req),
        .last    (last),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= IDX_W'(N_REQ - 1);
            grant_id  <= '0;
            uart_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (launch) begin
                last      <= winner;
                grant_id  <= winner;
                uart_data <= req_word[winner];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        launch  = 1'b0;
        done    = 1'b0;
        tx_err  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !uart_busy) begin
                    launch  = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                state_n = WAIT_BUSY;
                cnt_n   = '0;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CNT_W'(BUSY_TIMEOUT)) begin
                    done    = 1'b1;
                    tx_err  = 1'b1;
                    state_n = AFTER_ACK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    done    = 1'b1;
                    state_n = AFTER_ACK;
                    cnt_n   = '0;
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Enable is gated by busy so a misbehaving UART can never see a strobe mid-frame.
    always_comb begin
        ack = '0;
        if (done) ack[grant_id] = 1'b1;
    end

    assign uart_enable = (state == LAUNCH) && !uart_busy;
    assign arb_busy    = (state != IDLE);

endmodule
